// File: rtl/read_fmps_test_link.sv
// read_fmps_test_link: receive-side checker for the FMPS test link.
// Validates header framing, sequence continuity and payload content of the
// Aurora RX stream, keeps saturating good/error packet counters with sticky
// error flags, and measures FA-strobe-to-header latency.
module read_fmps_test_link #(
  parameter int CNT_WIDTH = 16,
  parameter int LAT_WIDTH = 10
) (
  input  logic                 auroraUserClk,
  input  logic                 auroraReset,
  input  logic                 auroraChannelUp,
  input  logic                 auroraFAstrobe,
  input  logic                 clearCounters,
  input  logic [31:0]          FMPS_TEST_AXI_STREAM_RX_tdata,
  input  logic                 FMPS_TEST_AXI_STREAM_RX_tvalid,
  input  logic                 FMPS_TEST_AXI_STREAM_RX_tlast,
  output logic [CNT_WIDTH-1:0] goodPackets,
  output logic [CNT_WIDTH-1:0] errorCount,
  output logic [3:0]           errFlags,
  output logic [15:0]          lastSeq,
  output logic [LAT_WIDTH-1:0] latency,
  output logic                 latencyOverrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Error bit positions inside errFlags and the per-packet error vectors.
  localparam int E_HDR  = 0;
  localparam int E_SEQ  = 1;
  localparam int E_DATA = 2;
  localparam int E_LEN  = 3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LAT_WIDTH-1:0] LAT_ONE = {{(LAT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_reg, state_next;
  logic [4:0]           n_reg, n_next;
  logic [4:0]           k_reg, k_next;
  logic [15:0]          seq_reg, seq_next;
  logic [3:0]           pend_reg, pend_next;
  logic [3:0]           err_now;
  logic [3:0]           err_all;
  logic                 synced_reg;
  logic                 lat_open_reg;
  logic [LAT_WIDTH-1:0] lat_cnt_reg;
  logic                 pkt_done;
  logic                 good_hdr;

  logic        word_valid;
  logic        word_last;
  logic [31:0] word;
  logic        hdr_ok;
  logic [4:0]  hdr_n;
  logic [15:0] hdr_seq;
  logic [15:0] seq_succ;
  logic [31:0] expected_word;
  logic        last_k;
  logic        strobe_start;
  logic        overrun_set;

  assign word_valid    = FMPS_TEST_AXI_STREAM_RX_tvalid;
  assign word_last     = FMPS_TEST_AXI_STREAM_RX_tlast;
  assign word          = FMPS_TEST_AXI_STREAM_RX_tdata;
  assign hdr_ok        = (word[31:24] == 8'hFA) && (word[23:21] == 3'd0);
  assign hdr_n         = word[20:16];
  assign hdr_seq       = word[15:0];
  assign seq_succ      = lastSeq + 16'd1;
  assign expected_word = {seq_reg, 11'd0, k_reg};
  assign last_k        = (k_reg == (n_reg - 5'd1));
  // Errors of the packet whose deciding word is on the bus this cycle.
  assign err_all       = pend_reg | err_now;

  // A strobe opens a new measurement unless one is open and not being closed now.
  assign strobe_start  = auroraFAstrobe && (!lat_open_reg || good_hdr);
  assign overrun_set   = auroraChannelUp && auroraFAstrobe && lat_open_reg && !good_hdr;

  // Packet parser: next state, per-word error detection and completion strobe.
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    k_next     = k_reg;
    seq_next   = seq_reg;
    pend_next  = pend_reg;
    err_now    = 4'd0;
    pkt_done   = 1'b0;
    good_hdr   = 1'b0;
    if (!auroraChannelUp) begin
      state_next = ST_IDLE;
      pend_next  = 4'd0;
    end else if (word_valid) begin
      case (state_reg)
        ST_IDLE: begin
          if (!hdr_ok) begin
            err_now[E_HDR] = 1'b1;
            pkt_done       = 1'b1;
            state_next     = word_last ? ST_IDLE : ST_DISCARD;
          end else begin
            good_hdr = 1'b1;
            n_next   = hdr_n;
            k_next   = 5'd0;
            seq_next = hdr_seq;
            if (synced_reg && (hdr_seq != seq_succ)) err_now[E_SEQ] = 1'b1;
            if (hdr_n == 5'd0) begin
              pkt_done = 1'b1;
              if (!word_last) begin
                err_now[E_LEN] = 1'b1;
                state_next     = ST_DISCARD;
              end
            end else if (word_last) begin
              err_now[E_LEN] = 1'b1;
              pkt_done       = 1'b1;
            end else begin
              state_next = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (word != expected_word) err_now[E_DATA] = 1'b1;
          if (word_last) begin
            pkt_done   = 1'b1;
            state_next = ST_IDLE;
            if (!last_k) err_now[E_LEN] = 1'b1;
          end else if (last_k) begin
            pkt_done       = 1'b1;
            state_next     = ST_DISCARD;
            err_now[E_LEN] = 1'b1;
          end else begin
            k_next = k_reg + 5'd1;
          end
        end
        ST_DISCARD: begin
          if (word_last) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
      pend_next = pkt_done ? 4'd0 : (pend_reg | err_now);
    end
  end

  // Parser state registers.
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      state_reg <= ST_IDLE;
      n_reg     <= 5'd0;
      k_reg     <= 5'd0;
      seq_reg   <= 16'd0;
      pend_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      k_reg     <= k_next;
      seq_reg   <= seq_next;
      pend_reg  <= pend_next;
    end
  end

  // Sequence tracking: lastSeq follows every good header; link loss drops sync.
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      synced_reg <= 1'b0;
      lastSeq    <= 16'd0;
    end else if (!auroraChannelUp) begin
      synced_reg <= 1'b0;
    end else if (good_hdr) begin
      synced_reg <= 1'b1;
      lastSeq    <= hdr_seq;
    end
  end

  // Saturating packet counters and sticky flags; a clear beats any same-cycle event.
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      goodPackets    <= '0;
      errorCount     <= '0;
      errFlags       <= 4'd0;
      latencyOverrun <= 1'b0;
    end else if (clearCounters) begin
      goodPackets    <= '0;
      errorCount     <= '0;
      errFlags       <= 4'd0;
      latencyOverrun <= 1'b0;
    end else begin
      if (pkt_done) begin
        if (|err_all) begin
          errFlags <= errFlags | err_all;
          if (errorCount != '1) errorCount <= errorCount + CNT_ONE;
        end else if (goodPackets != '1) begin
          goodPackets <= goodPackets + CNT_ONE;
        end
      end
      if (overrun_set) latencyOverrun <= 1'b1;
    end
  end

  // Latency measurement: counter reads L on the header L cycles after the strobe.
  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      lat_open_reg <= 1'b0;
      lat_cnt_reg  <= '0;
      latency      <= '0;
    end else if (!auroraChannelUp) begin
      lat_open_reg <= 1'b0;
    end else begin
      if (good_hdr && lat_open_reg) latency <= lat_cnt_reg;
      if (strobe_start) begin
        lat_open_reg <= 1'b1;
        lat_cnt_reg  <= LAT_ONE;
      end else begin
        if (good_hdr) lat_open_reg <= 1'b0;
        if (lat_cnt_reg != '1) lat_cnt_reg <= lat_cnt_reg + LAT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_read_fmps_test_link.sv
// Directed bench for read_fmps_test_link: packet-level reference model compared
// every cycle, plus hand-computed literal checkpoints.
module tb_read_fmps_test_link;

  localparam int CW = 16;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          chup = 1'b0;
  logic          stb = 1'b0;
  logic          clr = 1'b0;
  logic [31:0]   tdata = 32'd0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic [CW-1:0] good_packets;
  logic [CW-1:0] error_count;
  logic [3:0]    err_flags;
  logic [15:0]   last_seq;
  logic [LW-1:0] latency;
  logic          latency_overrun;

  always #5 clk = ~clk;

  read_fmps_test_link #(.CNT_WIDTH(CW), .LAT_WIDTH(LW)) dut (
    .auroraUserClk                 (clk),
    .auroraReset                   (rst),
    .auroraChannelUp               (chup),
    .auroraFAstrobe                (stb),
    .clearCounters                 (clr),
    .FMPS_TEST_AXI_STREAM_RX_tdata (tdata),
    .FMPS_TEST_AXI_STREAM_RX_tvalid(tvalid),
    .FMPS_TEST_AXI_STREAM_RX_tlast (tlast),
    .goodPackets                   (good_packets),
    .errorCount                    (error_count),
    .errFlags                      (err_flags),
    .lastSeq                       (last_seq),
    .latency                       (latency),
    .latencyOverrun                (latency_overrun)
  );

  int n_pass = 0;
  int n_total = 0;
  bit run_chk = 1'b0;

  // Reference model state
  int          m_good = 0;
  int          m_err = 0;
  logic [3:0]  m_flags = 4'd0;
  logic [15:0] m_last_seq = 16'd0;
  int          m_lat = 0;
  logic        m_ovr = 1'b0;
  logic        m_open = 1'b0;
  logic        m_synced = 1'b0;
  int          m_t0 = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("goodPackets", 32'(good_packets), 32'(m_good));
      chk("errorCount", 32'(error_count), 32'(m_err));
      chk("errFlags", 32'(err_flags), 32'(m_flags));
      chk("lastSeq", 32'(last_seq), 32'(m_last_seq));
      chk("latency", 32'(latency), 32'(m_lat));
      chk("latencyOverrun", 32'(latency_overrun), 32'(m_ovr));
    end
  end

  // One clock cycle: present inputs, then advance the model after the edge.
  task automatic step(input logic [31:0] d, input logic v, input logic l, input logic s,
                      input logic c, input logic hdr_good, input logic done,
                      input logic [3:0] fl, input logic [15:0] hseq);
    logic ovr_evt;
    int   dl;
    tdata = d; tvalid = v; tlast = l; stb = s; clr = c;
    @(posedge clk);
    #1;
    ovr_evt = 1'b0;
    if (!chup) begin
      m_open = 1'b0;
      m_synced = 1'b0;
    end else begin
      if (hdr_good) begin
        if (m_open) begin
          dl = cyc - m_t0;
          m_lat = (dl > 1023) ? 1023 : dl;
        end
        m_last_seq = hseq;
        m_synced = 1'b1;
      end
      if (s && m_open && !hdr_good) ovr_evt = 1'b1;
      else if (s) begin m_open = 1'b1; m_t0 = cyc; end
      else if (hdr_good) m_open = 1'b0;
    end
    if (c) begin
      m_good = 0; m_err = 0; m_flags = 4'd0; m_ovr = 1'b0;
    end else begin
      if (done) begin
        if (|fl) begin
          if (m_err < 65535) m_err++;
          m_flags = m_flags | fl;
        end else if (m_good < 65535) m_good++;
      end
      if (ovr_evt) m_ovr = 1'b1;
    end
    cyc++;
    tvalid = 1'b0; tlast = 1'b0; stb = 1'b0; clr = 1'b0;
  endtask

  task automatic idle();
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic strobe();
    step(32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic clear_pulse();
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  // Sends header + nw further words (tlast on the final one) and predicts the
  // outcome from the packet description.
  task automatic send_pkt(input logic [7:0] magic, input logic [2:0] rsv, input logic [4:0] n,
                          input logic [15:0] sq, input int nw, input int bad_k, input bit gaps,
                          input logic hstb, input logic clr_at_done);
    logic        magic_ok;
    logic [3:0]  fl;
    logic [31:0] w;
    int          done_w;
    magic_ok = (magic == 8'hFA) && (rsv == 3'd0);
    fl = 4'd0;
    done_w = 0;
    if (!magic_ok) begin
      fl[0] = 1'b1;
    end else begin
      fl[1] = m_synced && (sq != 16'(m_last_seq + 16'd1));
      if (n == 5'd0) begin
        if (nw != 0) fl[3] = 1'b1;
      end else if (nw == 0) begin
        fl[3] = 1'b1;
      end else if (nw < int'(n)) begin
        done_w = nw; fl[3] = 1'b1;
      end else if (nw == int'(n)) begin
        done_w = nw;
      end else begin
        done_w = int'(n); fl[3] = 1'b1;
      end
      if (bad_k >= 0 && bad_k < done_w) fl[2] = 1'b1;
    end
    for (int i = 0; i <= nw; i++) begin
      if (i == 0) w = {magic, rsv, n, sq};
      else begin
        w = {sq, 16'(i - 1)};
        if (i - 1 == bad_k) w = w ^ 32'h0000_0100;
      end
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) idle();
      step(w, 1'b1, (i == nw), (i == 0) ? hstb : 1'b0, (i == done_w) ? clr_at_done : 1'b0,
           (i == 0) && magic_ok, (i == done_w), fl, sq);
    end
  endtask

  task automatic pkt(input logic [15:0] sq, input logic [4:0] n);
    send_pkt(8'hFA, 3'd0, n, sq, int'(n), -1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    chup = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_good", 32'(good_packets), 32'd0);
    chk("rst_err", 32'(error_count), 32'd0);
    chk("rst_flags", 32'(err_flags), 32'd0);
    chk("rst_lastSeq", 32'(last_seq), 32'd0);
    chk("rst_latency", 32'(latency), 32'd0);
    chk("rst_ovr", 32'(latency_overrun), 32'd0);
    rst = 1'b0;
    chup = 1'b1;
    run_chk = 1'b1;
    idle();

    // Five back-to-back N=3 packets with random bubbles
    for (int s = 0; s < 5; s++)
      send_pkt(8'hFA, 3'd0, 5'd3, 16'(s), 3, -1, 1'b1, 1'b0, 1'b0);
    chk("five_good", 32'(good_packets), 32'd5);
    chk("five_err", 32'(error_count), 32'd0);
    chk("five_flags", 32'(err_flags), 32'd0);
    chk("five_lastSeq", 32'(last_seq), 32'd4);

    // Sequence jump 7 -> 9, then 10 is good
    pkt(16'd5, 5'd3); pkt(16'd6, 5'd3); pkt(16'd7, 5'd3);
    pkt(16'd9, 5'd3);
    chk("seqjump_err", 32'(error_count), 32'd1);
    chk("seqjump_flags", 32'(err_flags), 32'h2);
    pkt(16'd10, 5'd3);
    chk("seq10_good", 32'(good_packets), 32'd9);
    idle();

    // Payload corruption, early tlast, missing tlast
    clear_pulse();
    send_pkt(8'hFA, 3'd0, 5'd4, 16'd11, 4, 1, 1'b0, 1'b0, 1'b0);
    chk("corrupt_flags", 32'(err_flags), 32'h4);
    chk("corrupt_err", 32'(error_count), 32'd1);
    chk("corrupt_good", 32'(good_packets), 32'd0);
    send_pkt(8'hFA, 3'd0, 5'd4, 16'd12, 2, -1, 1'b0, 1'b0, 1'b0);
    chk("early_flags", 32'(err_flags), 32'hC);
    send_pkt(8'hFA, 3'd0, 5'd4, 16'd13, 6, -1, 1'b0, 1'b0, 1'b0);
    chk("missing_err", 32'(error_count), 32'd3);
    pkt(16'd14, 5'd4);
    chk("after_discard_good", 32'(good_packets), 32'd1);

    // Empty packet, then bad magic with discard
    pkt(16'd15, 5'd0);
    chk("n0_good", 32'(good_packets), 32'd2);
    send_pkt(8'hFB, 3'd0, 5'd2, 16'd16, 2, -1, 1'b0, 1'b0, 1'b0);
    chk("magic_flags", 32'(err_flags), 32'hD);
    chk("magic_err", 32'(error_count), 32'd4);
    pkt(16'd16, 5'd0);
    chk("post_magic_good", 32'(good_packets), 32'd3);
    chk("post_magic_lastSeq", 32'(last_seq), 32'd16);

    // Latency: 37-cycle measurement, overrun, strobe on a header cycle
    strobe();
    repeat (36) idle();
    pkt(16'd17, 5'd0);
    chk("latency37", 32'(latency), 32'd37);
    strobe();
    repeat (3) idle();
    strobe();
    chk("overrun_set", 32'(latency_overrun), 32'd1);
    pkt(16'd18, 5'd0);
    clear_pulse();
    strobe();
    repeat (9) idle();
    send_pkt(8'hFA, 3'd0, 5'd0, 16'd19, 0, -1, 1'b0, 1'b1, 1'b0);
    chk("latency10", 32'(latency), 32'd10);
    chk("no_overrun", 32'(latency_overrun), 32'd0);
    repeat (4) idle();
    pkt(16'd20, 5'd0);
    chk("latency5", 32'(latency), 32'd5);

    // Link drop mid-packet, then resync on seq 100
    step({8'hFA, 3'd0, 5'd3, 16'd50}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd50);
    step({16'd50, 16'd0}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    chup = 1'b0;
    repeat (3) idle();
    chup = 1'b1;
    idle();
    chk("drop_good", 32'(good_packets), 32'd2);
    chk("drop_err", 32'(error_count), 32'd0);
    chk("drop_lastSeq", 32'(last_seq), 32'd50);
    pkt(16'd100, 5'd2);
    chk("resync_good", 32'(good_packets), 32'd3);
    chk("resync_flags", 32'(err_flags), 32'd0);

    // Clear on the same cycle as an errored completion
    strobe();
    strobe();
    chk("overrun2", 32'(latency_overrun), 32'd1);
    send_pkt(8'hFA, 3'd0, 5'd1, 16'd200, 1, -1, 1'b0, 1'b0, 1'b1);
    chk("clr_good", 32'(good_packets), 32'd0);
    chk("clr_err", 32'(error_count), 32'd0);
    chk("clr_flags", 32'(err_flags), 32'd0);
    chk("clr_ovr", 32'(latency_overrun), 32'd0);
    pkt(16'd201, 5'd1);
    chk("final_good", 32'(good_packets), 32'd1);
    idle();

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/read_fmps_test_link.md
# read_fmps_test_link

Receive-side checker for the FMPS test link: consumes the 32-bit Aurora RX AXI stream produced by the FMPS test-link writer at the far end and validates packet framing, sequence continuity and payload content. It also measures latency from the local FA strobe to the next packet header. It sits in the Aurora user-clock domain between the FMPS Aurora RX port and the CSR readback logic. Counters and flags are read through the system CSR path via external CDC, which is outside this block.

## Interface
- `CNT_WIDTH`, 16: width of the good-packet and error counters (saturating).
- `LAT_WIDTH`, 10: width of the strobe-to-header latency counter (saturating).
- `auroraUserClk` input 1: sole clock; all logic rises on its positive edge.
- `auroraReset` input 1: asynchronous, active-high reset.
- `auroraChannelUp` input 1: link up; low forces the FSM to IDLE and clears sequence sync.
- `auroraFAstrobe` input 1: single-cycle FA strobe; starts the latency counter.
- `clearCounters` input 1: single-cycle pulse; zeroes counters and sticky flags.
- `FMPS_TEST_AXI_STREAM_RX_tdata` input 32: received word.
- `FMPS_TEST_AXI_STREAM_RX_tvalid` input 1: word valid. There is no tready; every valid word is accepted.
- `FMPS_TEST_AXI_STREAM_RX_tlast` input 1: last word of packet.
- `goodPackets` output CNT_WIDTH: packets that passed all checks.
- `errorCount` output CNT_WIDTH: packets with at least one error.
- `errFlags` output 4: sticky flags {length, data, sequence, header}, bits [3:0] = {3,2,1,0} respectively.
- `lastSeq` output 16: sequence field of the most recent valid header.
- `latency` output LAT_WIDTH: cycles from the last FA strobe to the following header.
- `latencyOverrun` output 1: sticky; a strobe arrived while the previous measurement was still open.

## Operation
- Packet format:
  - Header word: [31:24]=8'hFA, [23:21]=0, [20:16]=N (payload word count, 0..31), [15:0]=seq.
  - Payload word k (k=0..N-1): {seq, 16'(k)}.
  - tlast is asserted on the final word: the header itself when N=0, otherwise payload word N-1.
- FSM states, evaluated only on cycles where tvalid=1:
  - **IDLE**: expects a header.
    - Bad magic or nonzero [23:21]: header error; go to DISCARD if tlast=0, otherwise stay in IDLE.
    - Good header: latch N and seq, and update lastSeq.
    - Sequence check (only when synced): seq must equal previous seq + 1 mod 2^16, otherwise sequence error. After any good header the block is synced to the new seq.
    - N=0: tlast must be 1, otherwise length error and go to DISCARD.
    - N>0: tlast must be 0, otherwise length error. If tlast=0, go to PAYLOAD with k=0.
  - **PAYLOAD**:
    - A word mismatch sets a data error; the block keeps checking until the packet ends.
    - tlast at k<N-1: length error, go to IDLE.
    - No tlast at k=N-1: length error, go to DISCARD.
    - Otherwise increment k; at tlast go to IDLE.
  - **DISCARD**: drop words until tlast, then go to IDLE.
- Packet completion: the cycle on which the FSM returns to IDLE after a packet, or the cycle on which it enters DISCARD.
  - Exactly one of goodPackets or errorCount increments per packet, on that cycle.
  - Each error type sets its errFlags bit.
- Counters saturate at all-ones. clearCounters wins over a same-cycle increment; that event is lost.
- tvalid=0 cycles are ignored in every state. Bubbles inside a packet are legal.
- auroraChannelUp=0:
  - The FSM goes to IDLE, sequence sync is cleared and the latency measurement is aborted.
  - Counters and flags hold. A packet truncated this way is not counted.
- Latency:
  - auroraFAstrobe starts the counter at 0, or sets latencyOverrun if a measurement is already open.
  - The counter increments each cycle and saturates at all-ones.
  - The next good header captures the count into `latency` and closes the measurement. A header with no measurement open leaves `latency` unchanged.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE, unsynced, with no measurement open.
- All outputs are registered: counters, flags, lastSeq and latency update on the edge after the deciding word, so they are visible 1 cycle after that word is presented.
- Strobe and header on the same cycle: the header closes the old measurement (capturing the pre-strobe count) and the strobe opens a new one; no overrun is flagged.
- Latency definition: strobe at cycle t and header at cycle t+L gives latency=L.

## Test plan
- After reset, 5 back-to-back packets with seq 0..4 and N=3, with random tvalid gaps -> goodPackets=5, errorCount=0, errFlags=0, lastSeq=4.
- Sequence jump: seq 7 then seq 9 -> errorCount=1, errFlags[1]=1. The next packet with seq 10 -> counted as good.
- Corrupt payload word 1 of an N=4 packet -> errFlags[2]=1, errorCount=1, with no double count. Early tlast at k=1 of an N=4 packet -> errFlags[3]=1. Missing tlast at k=3 -> packet discarded until tlast, then the following packet is good.
- N=0 header with tlast -> good. Header magic 8'hFB -> errFlags[0]=1, and words are discarded until tlast.
- Strobe, then header 37 cycles later -> latency=37. A second strobe before any header -> latencyOverrun=1. Strobe and header on the same cycle -> no overrun.
- channelUp dropped mid-packet -> no count change. Header seq 100 after link up -> good, with no sequence error. clearCounters on the same cycle as a completion -> all counters and flags equal 0.
